// File: rtl/deskew_collector_int32.sv
// Deskew collector for the 4x4 systolic array output: lane c lags lane 0 by c cycles.
// It gathers one tile over a 2N-1 cycle window. Optional macro DESKEW_RELU_EN clamps negative captures to 0.

module deskew_lane #(
  parameter int N      = 4,
  parameter int DATA_W = 32,
  parameter int TW     = 3,
  parameter int LANE   = 0
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       cap_i,
  input  logic [TW-1:0]              t_i,
  input  logic [DATA_W-1:0]          val_i,
  output logic [N-1:0][DATA_W-1:0]   col_o
);
  localparam int RW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0][DATA_W-1:0] col_q;
  logic [TW:0]              rel;
  logic                     hit;
  logic [DATA_W-1:0]        st;

  // Row this lane delivers on window cycle t is t-LANE; outside 0..N-1 the lane is idle.
  assign rel = {1'b0, t_i} - (TW+1)'(LANE);
  assign hit = cap_i && ({1'b0, t_i} >= (TW+1)'(LANE)) && (rel < (TW+1)'(N));

`ifdef DESKEW_RELU_EN
  assign st = val_i[DATA_W-1] ? '0 : val_i;
`else
  assign st = val_i;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i)  col_q <= '0;
    else if (hit) col_q[rel[RW-1:0]] <= st;
  end

  assign col_o = col_q;
endmodule

module deskew_collector_int32 #(
  parameter int N      = 4,
  parameter int DATA_W = 32
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          start_i,
  input  logic [N-1:0][DATA_W-1:0]      col_val_i,
  output logic [N*N-1:0][DATA_W-1:0]    result_o,
  output logic                          result_valid_o,
  input  logic                          result_ready_i,
  output logic                          busy_o,
  output logic                          overrun_o
);
  localparam int TW = $clog2(2*N-1);
  localparam logic [TW-1:0] T_LAST = TW'(2*N-2);

  typedef enum logic [1:0] {IDLE, CAPTURE, HOLD} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] t_q, t_d;
  logic          overrun_q;
  logic          cap_en;
  logic [TW-1:0] cap_t;
  logic          ovr_set;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      t_q       <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      t_q       <= t_d;
      if (ovr_set) overrun_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    case (state_q)
      IDLE: if (start_i) begin
        state_d = CAPTURE;
        t_d     = TW'(1);
      end
      CAPTURE: if (t_q == T_LAST) begin
        state_d = HOLD;
        t_d     = '0;
      end else begin
        t_d = t_q + TW'(1);
      end
      HOLD: if (result_ready_i) begin
        // A start in the handshake cycle opens the next window with no bubble.
        state_d = start_i ? CAPTURE : IDLE;
        t_d     = start_i ? TW'(1) : '0;
      end
      default: begin
        state_d = IDLE;
        t_d     = '0;
      end
    endcase
  end

  always_comb begin
    cap_en         = 1'b0;
    cap_t          = '0;
    ovr_set        = 1'b0;
    busy_o         = (state_q != IDLE);
    result_valid_o = (state_q == HOLD);
    case (state_q)
      IDLE:    cap_en = start_i;
      CAPTURE: begin
        cap_en  = 1'b1;
        cap_t   = t_q;
        ovr_set = start_i;
      end
      HOLD: begin
        cap_en  = start_i && result_ready_i;
        ovr_set = start_i && !result_ready_i;
      end
      default: ;
    endcase
  end

  logic [N-1:0][N-1:0][DATA_W-1:0] lane_col;

  for (genvar c = 0; c < N; c++) begin : g_lane
    deskew_lane #(.N(N), .DATA_W(DATA_W), .TW(TW), .LANE(c)) u_lane (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .cap_i   (cap_en),
      .t_i     (cap_t),
      .val_i   (col_val_i[c]),
      .col_o   (lane_col[c])
    );
    for (genvar r = 0; r < N; r++) begin : g_row
      assign result_o[N*r+c] = lane_col[c][r];
    end
  end

  assign overrun_o = overrun_q;
endmodule

// File: tb/tb_deskew_collector_int32.sv
// Self-checking bench for deskew_collector_int32: directed scenarios plus random traffic
// compared each cycle against a window-level model of the tile. Honors DESKEW_RELU_EN.

module tb_deskew_collector_int32;
  localparam int N = 4;
  localparam int W = 32;

  logic                   clk = 1'b0;
  logic                   rst, start, ready;
  logic [N-1:0][W-1:0]    col;
  logic [N*N-1:0][W-1:0]  res;
  logic                   valid, busy, ovr;

  deskew_collector_int32 #(.N(N), .DATA_W(W)) dut (
    .clk_i          (clk),
    .reset_i        (rst),
    .start_i        (start),
    .col_val_i      (col),
    .result_o       (res),
    .result_valid_o (valid),
    .result_ready_i (ready),
    .busy_o         (busy),
    .overrun_o      (ovr)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  bit chk_en = 1'b0;

  logic [W-1:0] exp_res [N*N];
  int  cap_t   = -1;
  bit  holding = 1'b0;
  bit  exp_ov  = 1'b0;

  function automatic logic [W-1:0] store(input logic [W-1:0] v);
`ifdef DESKEW_RELU_EN
    return v[W-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] ex);
    n_chk++;
    if (act === ex) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, ex);
  endtask

  // Window cycle t writes row t-c of lane c.
  task automatic model_cap(input int t);
    for (int c = 0; c < N; c++)
      if (t - c >= 0 && t - c < N) exp_res[N*(t-c)+c] = store(col[c]);
  endtask

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N*N; i++) exp_res[i] = '0;
      cap_t = -1; holding = 1'b0; exp_ov = 1'b0;
    end else if (cap_t >= 0) begin
      model_cap(cap_t);
      if (start) exp_ov = 1'b1;
      if (cap_t == 2*N-2) begin holding = 1'b1; cap_t = -1; end
      else cap_t++;
    end else if (holding) begin
      if (ready) begin
        holding = 1'b0;
        if (start) begin model_cap(0); cap_t = 1; end
      end else if (start) exp_ov = 1'b1;
    end else if (start) begin
      model_cap(0); cap_t = 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      int idx = 0;
      for (int i = N*N-1; i >= 0; i--) if (res[i] !== exp_res[i]) idx = i;
      chk("valid", valid, holding);
      chk("busy", busy, (cap_t >= 0) || holding);
      chk("overrun", ovr, exp_ov);
      chk($sformatf("result[%0d]", idx), res[idx], exp_res[idx]);
    end
  end

  task automatic step(input bit s, input bit r, input bit rs);
    start = s; ready = r; rst = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic set_pat(input int t, input int base);
    for (int c = 0; c < N; c++)
      col[c] = (t - c >= 0 && t - c < N) ? W'(base + 100*(t-c) + c) : 32'hDEAD;
  endtask

  initial begin
    logic [W-1:0] orall;
    col = '0;
    step(1'b0, 1'b0, 1'b1);
    chk_en = 1'b1;
    chk("reset_valid", valid, 0);
    chk("reset_res0", res[0], 0);

    // Tile with DEAD filler on inactive lanes
    for (int t = 0; t < 2*N-1; t++) begin set_pat(t, 0); step(t == 0, 1'b0, 1'b0); end
    chk("t1_valid", valid, 1);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        chk($sformatf("t1_res%0d", N*r+c), res[N*r+c], W'(100*r + c));

    // Back-pressure then release
    for (int i = 0; i < 5; i++) begin col = {$urandom, $urandom, $urandom, $urandom}; step(1'b0, 1'b0, 1'b0); end
    chk("t2_valid_held", valid, 1);
    chk("t2_res11", res[11], 203);
    step(1'b0, 1'b1, 1'b0);
    chk("t2_valid_drop", valid, 0);
    chk("t2_busy", busy, 0);

    // Start mid-window is dropped and flagged
    for (int t = 0; t < 2*N-1; t++) begin set_pat(t, 200); step(t == 0 || t == 3, 1'b0, 1'b0); end
    chk("t3_ovr", ovr, 1);
    chk("t3_valid", valid, 1);
    chk("t3_res15", res[15], 503);
    step(1'b0, 1'b1, 1'b0);
    chk("t3_ovr_sticky", ovr, 1);

    // Back-to-back tiles through the handshake cycle
    for (int t = 0; t < 2*N-1; t++) begin set_pat(t, 300); step(t == 0, 1'b0, 1'b0); end
    chk("t4_first_valid", valid, 1);
    for (int t = 0; t < 2*N-1; t++) begin
      set_pat(t, 1000); step(t == 0, t == 0, 1'b0);
      chk("t4_busy", busy, 1);
      if (t == 2*N-2) chk("t4_valid_on_time", valid, 1);
      else            chk("t4_valid_early", valid, 0);
    end
    chk("t4_res0", res[0], 1000);
    chk("t4_res15", res[15], 1303);
    step(1'b0, 1'b1, 1'b0);

    // Reset in mid-window
    for (int t = 0; t < 4; t++) begin set_pat(t, 500); step(t == 0, 1'b0, 1'b0); end
    set_pat(4, 500); step(1'b0, 1'b0, 1'b1);
    orall = '0;
    for (int i = 0; i < N*N; i++) orall |= res[i];
    chk("t5_res_cleared", orall, 0);
    chk("t5_valid", valid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_ovr", ovr, 0);
    for (int t = 0; t < 2*N-1; t++) begin set_pat(t, 700); step(t == 0, 1'b0, 1'b0); end
    chk("t5_valid_fresh", valid, 1);
    chk("t5_res5", res[5], 801);
    step(1'b0, 1'b1, 1'b0);

    // All-negative input
    for (int t = 0; t < 2*N-1; t++) begin
      for (int c = 0; c < N; c++) col[c] = 32'hFFFFFFFB;
      step(t == 0, 1'b0, 1'b0);
    end
    for (int i = 0; i < N*N; i++)
`ifdef DESKEW_RELU_EN
      chk($sformatf("t6_res%0d", i), res[i], 0);
`else
      chk($sformatf("t6_res%0d", i), res[i], 32'hFFFFFFFB);
`endif
    step(1'b0, 1'b1, 1'b0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < N; c++) col[c] = $urandom;
      step($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 79) == 0);
    end

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
